// File: rtl/step_seq_pkg.sv
// Shared constants for the three-axis step sequencer: FSM state codes,
// end-cause codes and default timing values.
package step_seq_pkg;

  localparam int PULSE_CYCLES_DEF = 16;
  localparam int DIR_SETUP_DEF    = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_PULSE = 2'd2;
  localparam logic [1:0] ST_LOW   = 2'd3;

  localparam logic [1:0] CAUSE_DONE  = 2'd0;
  localparam logic [1:0] CAUSE_LIMIT = 2'd1;
  localparam logic [1:0] CAUSE_FAULT = 2'd2;
  localparam logic [1:0] CAUSE_STOP  = 2'd3;

  // Cause codes are ordered so that a higher value means a higher priority.
  function automatic logic [1:0] max_cause(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axis_stepper.sv
// One motor axis: DIR setup, fixed-width STEP pulses at the programmed period,
// stop handling and sticky done/cause flags. STEP_SEQ_HOLD_EN keeps ENABLE after a clean finish.
module axis_stepper
  import step_seq_pkg::*;
#(
  parameter int CNT_W        = 24,
  parameter int PER_W        = 16,
  parameter int PULSE_CYCLES = PULSE_CYCLES_DEF,
  parameter int DIR_SETUP    = DIR_SETUP_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dir_in,
  input  logic [CNT_W-1:0] steps_in,
  input  logic [PER_W-1:0] period_in,
  input  logic             abort,
  input  logic             fault,
  input  logic             lim_min,
  input  logic             lim_max,
  input  logic             irq_ack,
  output logic             m_step,
  output logic             m_dir,
  output logic             m_enable,
  output logic             busy,
  output logic             done,
  output logic [1:0]       cause
);

  localparam int TMR_MAX = (PULSE_CYCLES > DIR_SETUP) ? PULSE_CYCLES : DIR_SETUP;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [PER_W-1:0] MIN_PER = PER_W'(2 * PULSE_CYCLES);

  logic [1:0]       state;
  logic [TMR_W-1:0] tmr;
  logic [PER_W-1:0] per_cnt;
  logic [PER_W-1:0] eff;
  logic [CNT_W-1:0] rem;
  logic [1:0]       pend;
  logic             dir_r;
  logic             done_r;
  logic [1:0]       cause_r;

  logic       lim_hit;
  logic       stop_now;
  logic [1:0] stop_code;
  logic       fin;
  logic [1:0] fin_cause;

  // Only the limit ahead of the direction of travel matters.
  assign lim_hit  = dir_r ? lim_max : lim_min;
  assign stop_now = abort | fault | lim_hit;

  always_comb begin
    stop_code = CAUSE_DONE;
    if (lim_hit) stop_code = CAUSE_LIMIT;
    if (fault)   stop_code = CAUSE_FAULT;
    if (abort)   stop_code = CAUSE_STOP;
  end

  always_comb begin
    fin       = 1'b0;
    fin_cause = CAUSE_DONE;
    case (state)
      ST_IDLE:  fin = start && (steps_in == '0);
      ST_SETUP: begin
        fin       = stop_now;
        fin_cause = stop_code;
      end
      ST_PULSE: begin
        if (tmr == '0 && (stop_now || pend != CAUSE_DONE)) begin
          fin       = 1'b1;
          fin_cause = max_cause(pend, stop_code);
        end
      end
      ST_LOW: begin
        if (stop_now) begin
          fin       = 1'b1;
          fin_cause = stop_code;
        end else if (per_cnt == '0 && rem == CNT_W'(1)) begin
          fin = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      tmr     <= '0;
      per_cnt <= '0;
      eff     <= '0;
      rem     <= '0;
      pend    <= CAUSE_DONE;
      dir_r   <= 1'b0;
      done_r  <= 1'b0;
      cause_r <= CAUSE_DONE;
    end else begin
      done_r <= fin | (done_r & ~irq_ack);
      if (fin) cause_r <= fin_cause;
      case (state)
        ST_IDLE: begin
          if (start) begin
            dir_r <= dir_in;
            eff   <= (period_in < MIN_PER) ? MIN_PER : period_in;
            rem   <= steps_in;
            pend  <= CAUSE_DONE;
            tmr   <= TMR_W'(DIR_SETUP - 1);
            if (steps_in != '0) state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (stop_now) begin
            state <= ST_IDLE;
          end else if (tmr == '0) begin
            state   <= ST_PULSE;
            tmr     <= TMR_W'(PULSE_CYCLES - 1);
            per_cnt <= eff - 1'b1;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        ST_PULSE: begin
          // A pulse always runs to full width; stops seen meanwhile are remembered.
          per_cnt <= per_cnt - 1'b1;
          if (stop_now) pend <= max_cause(pend, stop_code);
          if (tmr == '0) state <= fin ? ST_IDLE : ST_LOW;
          else           tmr   <= tmr - 1'b1;
        end
        ST_LOW: begin
          if (stop_now) begin
            state <= ST_IDLE;
          end else if (per_cnt == '0) begin
            if (rem == CNT_W'(1)) begin
              state <= ST_IDLE;
            end else begin
              rem     <= rem - 1'b1;
              state   <= ST_PULSE;
              tmr     <= TMR_W'(PULSE_CYCLES - 1);
              per_cnt <= eff - 1'b1;
            end
          end else begin
            per_cnt <= per_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign m_step = (state == ST_PULSE);
  assign busy   = (state != ST_IDLE);
  assign m_dir  = dir_r;
  assign done   = done_r;
  assign cause  = cause_r;

`ifdef STEP_SEQ_HOLD_EN
  logic hold;
  always_ff @(posedge clk) begin
    if (reset)               hold <= 1'b0;
    else if (abort || fault) hold <= 1'b0;
    else if (fin)            hold <= (fin_cause == CAUSE_DONE);
  end
  assign m_enable = busy | hold;
`else
  assign m_enable = busy;
`endif

endmodule

// File: rtl/step_sequencer.sv
// Three-axis step pulse scheduler: command decode, emergency-stop fan-out, error flag and irq.
// Optional holding torque after clean moves is enabled by defining STEP_SEQ_HOLD_EN.
module step_sequencer
  import step_seq_pkg::*;
#(
  parameter int AXES         = 3,
  parameter int CNT_W        = 24,
  parameter int PER_W        = 16,
  parameter int PULSE_CYCLES = PULSE_CYCLES_DEF,
  parameter int DIR_SETUP    = DIR_SETUP_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_axis,
  input  logic                cmd_dir,
  input  logic [CNT_W-1:0]    cmd_steps,
  input  logic [PER_W-1:0]    cmd_period,
  input  logic [AXES-1:0]     abort,
  input  logic [AXES-1:0]     irq_ack,
  input  logic [AXES-1:0]     m_fault,
  input  logic [2*AXES-1:0]   m_stop,
  input  logic                em_stop,
  output logic [AXES-1:0]     m_step,
  output logic [AXES-1:0]     m_dir,
  output logic [AXES-1:0]     m_enable,
  output logic [AXES-1:0]     busy,
  output logic [AXES-1:0]     done,
  output logic [2*AXES-1:0]   cause,
  output logic                cmd_err,
  output logic                irq
);

  logic accept;

  // Axis code 3 is always taken (then dropped) so the host never stalls on it.
  always_comb begin
    cmd_ready = 1'b0;
    if (cmd_axis == 2'd3) cmd_ready = 1'b1;
    for (int a = 0; a < AXES; a++) begin
      if (cmd_axis == 2'(a)) cmd_ready = ~busy[a] & ~m_fault[a];
    end
    if (reset || em_stop) cmd_ready = 1'b0;
  end

  assign accept = cmd_valid & cmd_ready;

  always_ff @(posedge clk) begin
    if (reset)                             cmd_err <= 1'b0;
    else if (accept && cmd_axis == 2'd3)   cmd_err <= 1'b1;
  end

  assign irq = |done;

  for (genvar a = 0; a < AXES; a++) begin : g_axis
    axis_stepper #(
      .CNT_W       (CNT_W),
      .PER_W       (PER_W),
      .PULSE_CYCLES(PULSE_CYCLES),
      .DIR_SETUP   (DIR_SETUP)
    ) u_axis (
      .clk      (clk),
      .reset    (reset),
      .start    (accept && cmd_axis == 2'(a)),
      .dir_in   (cmd_dir),
      .steps_in (cmd_steps),
      .period_in(cmd_period),
      .abort    (abort[a] | em_stop),
      .fault    (m_fault[a]),
      .lim_min  (m_stop[2*a]),
      .lim_max  (m_stop[2*a+1]),
      .irq_ack  (irq_ack[a]),
      .m_step   (m_step[a]),
      .m_dir    (m_dir[a]),
      .m_enable (m_enable[a]),
      .busy     (busy[a]),
      .done     (done[a]),
      .cause    (cause[2*a +: 2])
    );
  end

endmodule

// File: tb/tb_step_sequencer.sv
// Scoreboard bench for step_sequencer: stimulus pushes predicted moves, a monitor
// checks every STEP rise, pulse width and end-of-move against them.
module tb_step_sequencer;

  localparam int AX   = 3;
  localparam int PC   = 16;
  localparam int DS   = 8;
  localparam int MINP = 2 * PC;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_axis;
  logic        cmd_dir;
  logic [23:0] cmd_steps;
  logic [15:0] cmd_period;
  logic [2:0]  abort, irq_ack, m_fault;
  logic [5:0]  m_stop;
  logic        em_stop;
  logic [2:0]  m_step, m_dir, m_enable, busy, done;
  logic [5:0]  cause;
  logic        cmd_err, irq;

  step_sequencer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_axis(cmd_axis), .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_period(cmd_period),
    .abort(abort), .irq_ack(irq_ack), .m_fault(m_fault), .m_stop(m_stop), .em_stop(em_stop),
    .m_step(m_step), .m_dir(m_dir), .m_enable(m_enable), .busy(busy), .done(done),
    .cause(cause), .cmd_err(cmd_err), .irq(irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int count;
    int first;
    int eff;
    int dir;
    int end_c;
    int cause;
  } exp_t;

  exp_t exp_q[AX][$];
  int   last_end[AX];

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int effp(input int p);
    return (p < MINP) ? MINP : p;
  endfunction

  task automatic push_move(input int a, input int dir, input int steps, input int period, input int n);
    exp_t e;
    e.first = n + 1 + DS;
    e.eff   = effp(period);
    e.count = steps;
    e.dir   = dir;
    e.end_c = e.first + steps * e.eff;
    e.cause = 0;
    exp_q[a].push_back(e);
    last_end[a] = e.end_c;
  endtask

  // Stop condition first seen in cycle m: no rise after m, a running pulse completes.
  task automatic apply_stop(input int a, input int m, input int c);
    exp_t e;
    int   i, r;
    i = exp_q[a].size() - 1;
    if (i < 0) return;
    e = exp_q[a][i];
    if (m >= e.end_c) return;
    if (m < e.first) e.count = 0;
    else if ((m - e.first) / e.eff + 1 < e.count) e.count = (m - e.first) / e.eff + 1;
    r = e.first + (e.count - 1) * e.eff;
    if (e.count > 0 && m <= r + PC - 1) e.end_c = r + PC;
    else e.end_c = m + 1;
    e.cause = c;
    exp_q[a][i] = e;
  endtask

  task automatic send(input int a, input int dir, input int steps, input int period,
                      output int n, output bit waited);
    int g;
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_axis   = 2'(a);
    cmd_dir    = dir[0];
    cmd_steps  = 24'(steps);
    cmd_period = 16'(period);
    #1;
    waited = 1'b0;
    g = 0;
    while (!cmd_ready && g < 5000) begin
      waited = 1'b1;
      @(negedge clk);
      #1;
      g++;
    end
    if (g >= 5000) check(1'b0, "accept_timeout", 0, 1);
    n = cyc;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_until(input int t);
    @(negedge clk);
    while (cyc < t) @(negedge clk);
    if (cyc != t) check(1'b0, "schedule_missed", cyc, t);
  endtask

  task automatic wait_idle(input logic [2:0] mask);
    int g = 0;
    while ((busy & mask) != 3'b000 && g < 20000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 20000) check(1'b0, "idle_timeout", busy, 0);
    @(negedge clk);
  endtask

  // Monitor
  bit [2:0] pst, pbusy;
  int rk[AX];
  int rise_at[AX];

  initial begin
    pst = '0;
    pbusy = '0;
    for (int a = 0; a < AX; a++) begin
      rk[a] = 0;
      rise_at[a] = 0;
    end
    forever begin
      @(posedge clk);
      #2;
      for (int a = 0; a < AX; a++) begin
        if (m_step[a] && !pst[a]) begin
          if (exp_q[a].size() == 0) check(1'b0, "unexpected_rise", a, -1);
          else begin
            check(rk[a] < exp_q[a][0].count, "rise_count", rk[a] + 1, exp_q[a][0].count);
            check(cyc == exp_q[a][0].first + rk[a] * exp_q[a][0].eff, "rise_time", cyc,
                  exp_q[a][0].first + rk[a] * exp_q[a][0].eff);
            check(m_dir[a] == exp_q[a][0].dir[0], "dir_at_rise", m_dir[a], exp_q[a][0].dir);
          end
          rk[a]++;
          rise_at[a] = cyc;
        end
        if (!m_step[a] && pst[a]) check(cyc - rise_at[a] == PC, "pulse_width", cyc - rise_at[a], PC);
        if (!busy[a] && pbusy[a]) begin
          if (exp_q[a].size() == 0) check(1'b0, "unexpected_end", a, -1);
          else begin
            exp_t e;
            e = exp_q[a].pop_front();
            check(rk[a] == e.count, "pulse_total", rk[a], e.count);
            check(cyc == e.end_c, "end_cycle", cyc, e.end_c);
            check(int'(cause[2*a +: 2]) == e.cause, "end_cause", cause[2*a +: 2], e.cause);
            check(done[a] == 1'b1, "done_at_end", done[a], 1);
            check(irq == 1'b1, "irq_at_end", irq, 1);
          end
          rk[a] = 0;
        end
`ifndef STEP_SEQ_HOLD_EN
        if (m_enable[a] != busy[a]) check(1'b0, "enable_vs_busy", m_enable[a], busy[a]);
`endif
      end
      pst = m_step;
      pbusy = busy;
    end
  end

  initial begin
    int n, n0, n1, n2, m, e_c, a, st, per, dir;
    bit w, bad;
    reset = 1'b1; cmd_valid = 1'b1; cmd_axis = 2'd0; cmd_dir = 1'b0;
    cmd_steps = 24'd1; cmd_period = 16'd40;
    abort = '0; irq_ack = '0; m_fault = '0; m_stop = '0; em_stop = 1'b0;
    for (int i = 0; i < AX; i++) last_end[i] = 0;

    repeat (3) @(negedge clk);
    #1;
    check(cmd_ready == 1'b0, "ready_in_reset", cmd_ready, 0);
    check(busy == 3'b000, "reset_busy", busy, 0);
    check(done == 3'b000, "reset_done", done, 0);
    check(cause == 6'd0, "reset_cause", cause, 0);
    check({m_step, m_dir, m_enable} == 9'd0, "reset_pins", {m_step, m_dir, m_enable}, 0);
    check(cmd_err == 1'b0 && irq == 1'b0, "reset_err_irq", {cmd_err, irq}, 0);
    @(negedge clk);
    reset = 1'b0;
    cmd_valid = 1'b0;

    // single step, long period
    send(0, 1, 1, 100, n, w);
    push_move(0, 1, 1, 100, n);
    #1;
    check(m_dir[0] == 1'b1, "dir_after_accept", m_dir[0], 1);
    check(busy[0] == 1'b1 && m_enable[0] == 1'b1, "busy_en_after_accept", {busy[0], m_enable[0]}, 3);
    wait_idle(3'b001);

    // period below minimum
    send(1, 0, 4, 10, n, w);
    push_move(1, 0, 4, 10, n);
    wait_idle(3'b010);

    // limit opposite travel ignored, then limit in travel direction
    m_stop[5] = 1'b1;
    send(2, 0, 3, 40, n, w);
    push_move(2, 0, 3, 40, n);
    wait_idle(3'b100);
    m_stop[5] = 1'b0;
    send(2, 0, 100, 40, n, w);
    push_move(2, 0, 100, 40, n);
    m = n + 1 + DS + 85;
    wait_until(m);
    m_stop[4] = 1'b1;
    apply_stop(2, m, 1);
    wait_idle(3'b100);
    m_stop[4] = 1'b0;

    // driver fault during LOW
    send(1, 1, 10, 50, n, w);
    push_move(1, 1, 10, 50, n);
    m = n + 1 + DS + 70;
    wait_until(m);
    m_fault[1] = 1'b1;
    apply_stop(1, m, 2);
    @(negedge clk);
    cmd_axis = 2'd1;
    #1;
    check(cmd_ready == 1'b0, "ready_on_fault", cmd_ready, 0);
    wait_idle(3'b010);
    m_fault[1] = 1'b0;

    // emergency stop during concurrent moves
    send(0, 1, 20, 40, n0, w);
    push_move(0, 1, 20, 40, n0);
    send(1, 0, 20, 33, n1, w);
    push_move(1, 0, 20, 33, n1);
    send(2, 1, 20, 60, n2, w);
    push_move(2, 1, 20, 60, n2);
    m = cyc + 25;
    wait_until(m);
    em_stop = 1'b1;
    for (int i = 0; i < AX; i++) apply_stop(i, m, 3);
    for (int i = 0; i < 4; i++) begin
      cmd_axis = 2'(i);
      #1;
      check(cmd_ready == 1'b0, "ready_on_estop", cmd_ready, 0);
    end
    repeat (PC) @(negedge clk);
    check(busy == 3'b000, "estop_all_idle", busy, 0);
    em_stop = 1'b0;
    @(negedge clk);

    // invalid axis
    check(cmd_err == 1'b0, "cmd_err_before", cmd_err, 0);
    send(3, 1, 5, 40, n, w);
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (m_step != 3'b000 || busy != 3'b000) bad = 1'b1;
    end
    check(bad == 1'b0, "axis3_no_activity", bad, 0);
    check(cmd_err == 1'b1, "cmd_err_set", cmd_err, 1);

    // zero steps
    @(negedge clk);
    irq_ack = 3'b111;
    @(negedge clk);
    irq_ack = 3'b000;
    #1;
    check(done == 3'b000 && irq == 1'b0, "ack_clears_all", {done, irq}, 0);
    send(1, 1, 0, 40, n, w);
    #1;
    check(done[1] == 1'b1 && busy[1] == 1'b0, "zero_steps_done", {done[1], busy[1]}, 2);
    check(cause[3:2] == 2'd0, "zero_steps_cause", cause[3:2], 0);

    // ack in the same cycle as the set
    @(negedge clk);
    irq_ack = 3'b111;
    @(negedge clk);
    irq_ack = 3'b000;
    send(0, 0, 1, 40, n, w);
    push_move(0, 0, 1, 40, n);
    e_c = n + 1 + DS + 40;
    wait_until(e_c - 1);
    irq_ack[0] = 1'b1;
    @(negedge clk);
    #1;
    check(done[0] == 1'b1 && irq == 1'b1, "set_beats_ack", {done[0], irq}, 3);
    @(negedge clk);
    irq_ack[0] = 1'b0;
    #1;
    check(done[0] == 1'b0 && irq == 1'b0, "second_ack_clears", {done[0], irq}, 0);

    // random overlapping commands, including hold-off on busy axes
    for (int i = 0; i < 15; i++) begin
      a   = $urandom_range(0, 2);
      dir = $urandom_range(0, 1);
      st  = $urandom_range(1, 5);
      per = $urandom_range(0, 80);
      send(a, dir, st, per, n, w);
      if (w) check(n == last_end[a], "holdoff_accept", n, last_end[a]);
      push_move(a, dir, st, per, n);
    end
    wait_idle(3'b111);

    // random moves with random aborts
    for (int i = 0; i < 10; i++) begin
      a   = $urandom_range(0, 2);
      dir = $urandom_range(0, 1);
      st  = $urandom_range(1, 4);
      per = $urandom_range(0, 70);
      send(a, dir, st, per, n, w);
      push_move(a, dir, st, per, n);
      if ($urandom_range(0, 1) == 1) begin
        m = n + 1 + $urandom_range(0, DS + st * effp(per));
        wait_until(m);
        abort[a] = 1'b1;
        apply_stop(a, m, 3);
        @(negedge clk);
        abort[a] = 1'b0;
      end
      wait_idle(3'b111);
    end

    repeat (3) @(negedge clk);
    for (int i = 0; i < AX; i++)
      check(exp_q[i].size() == 0, "scoreboard_drained", exp_q[i].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/step_sequencer.md
# step_sequencer

Three-axis step pulse scheduler that sits inside the motor controller, between the register bank fed by the SPI bus FSM and the motor driver pins. It accepts one move command per axis (direction, step count, step period), enforces DIR setup time and minimum STEP pulse width, and sequences the pulses. It halts axes on limit switch, driver fault or emergency stop, and raises a level interrupt when moves finish.

## Interface
- AXES, 3, number of motor channels (cmd_axis encoding fixed to 2 bits)
- CNT_W, 24, step count width
- PER_W, 16, step period width in clk cycles
- PULSE_CYCLES, 16, STEP high time in cycles (2 µs at 8 MHz)
- DIR_SETUP, 8, cycles from DIR/ENABLE update to first STEP rise

Ports:
- clk  in  1  system clock; the design's single clock
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when valid&ready
- cmd_axis  in  2  target axis; 3 is invalid
- cmd_dir  in  1  direction: 1 = toward max limit
- cmd_steps  in  CNT_W  number of steps
- cmd_period  in  PER_W  rising-to-rising step period
- abort  in  AXES  per-axis stop request, sampled every cycle
- irq_ack  in  AXES  write-1-to-clear done flags
- m_fault  in  AXES  driver fault, active-high
- m_stop  in  2*AXES  limits: bit 2a = axis a min, bit 2a+1 = axis a max
- em_stop  in  1  emergency stop, all axes
- m_step, m_dir, m_enable  out  AXES  driver pins
- busy  out  AXES  axis not IDLE
- done  out  AXES  sticky completion flags
- cause  out  2*AXES  per-axis end cause: 0 complete, 1 limit, 2 fault, 3 estop/abort
- cmd_err  out  1  sticky: command with cmd_axis=3 was accepted
- irq  out  1  OR of done

## Operation
- Per-axis FSM: IDLE -> SETUP -> PULSE -> LOW -> (PULSE | IDLE).
- Accept when the target axis is IDLE, em_stop=0 and the axis has no fault. cmd_ready is combinational on cmd_axis. cmd_ready=0 while reset=1. cmd_axis=3 is accepted, dropped, and sets cmd_err.
- On accept: latch dir, steps, and eff_period = max(cmd_period, 2*PULSE_CYCLES). Drive m_dir and m_enable, then enter SETUP.
- SETUP: count DIR_SETUP cycles, then go to PULSE.
- PULSE: m_step=1 for PULSE_CYCLES, then go to LOW.
- LOW: hold until eff_period has elapsed since the rise, then decrement remaining.
  - remaining=0 -> IDLE with done set and cause=0.
  - otherwise -> PULSE.
- cmd_steps=0: accepted, no pulses, done set and cause=0 on the next cycle.
- Stop conditions:
  - limit in the direction of travel -> cause 1
  - m_fault -> cause 2
  - abort or em_stop -> cause 3
  - Priority when simultaneous: 3 > 2 > 1.
- Stop behaviour by state:
  - In SETUP or LOW: go to IDLE on the next edge.
  - In PULSE: finish the full PULSE_CYCLES, then go to IDLE.
  - No new pulse is ever started after a stop condition.
  - done is set on the transition to IDLE.
- Limit on the opposite side of travel is ignored.
- done bit: irq_ack clears it. If set and ack occur in the same cycle, set wins.
- Reset values: m_step, m_dir, m_enable, busy, done, cause, cmd_err, irq all 0. All FSMs go to IDLE.
- Reset mid-move truncates a pulse in progress; this is accepted behaviour.

## Timing
- Accept at cycle N:
  - busy=1, m_dir and m_enable valid at N+1.
  - First m_step rise at N+1+DIR_SETUP.
- Rise-to-rise spacing is exactly eff_period. High time is exactly PULSE_CYCLES.
- busy falls at (last rise + eff_period). done and irq are high in that same cycle.
- A stop condition seen in cycle M during SETUP/LOW gives busy=0 at M+1.
- A new command to the same axis is acceptable in the first cycle busy=0.

## Configuration
- STEP_SEQ_HOLD_EN defined:
  - m_enable stays 1 after a move completes with cause 0 (holding torque).
  - It clears on fault, abort, em_stop or reset.
- Not defined: m_enable=1 only while busy.

## Structure
- Shared package step_seq_pkg: FSM state enum, cause code constants, default PULSE_CYCLES/DIR_SETUP.
- One sub-module, axis_stepper: the per-axis FSM, counters and flags, instantiated AXES times.
- Top level holds:
  - command decode and cmd_ready mux
  - em_stop fan-out
  - cmd_err
  - irq OR

## Test plan
- Axis 0, dir=1, steps=1, period=100, accept at cycle 0 -> m_dir=1 at 1, m_step high cycles 9–24, busy=0 and done[0]=1 at 109, cause=0.
- Axis 1, steps=4, period=10 (below minimum) -> 4 pulses spaced 32 cycles, each 16 high.
- Axis 2, dir=0, steps=100, assert m_stop[4] (min) during pulse 3 -> pulse 3 finishes at full width, exactly 3 pulses total, cause=1. Asserting m_stop[5] (max) instead has no effect.
- em_stop during concurrent moves on all axes -> all idle within PULSE_CYCLES+1, cause=3 everywhere, cmd_ready=0 while em_stop=1.
- cmd_valid to busy axis 0 -> held off until busy falls, accepted that cycle. cmd_axis=3 -> cmd_err=1, no pin activity.
- irq_ack[0] in the same cycle done[0] is set -> done[0] stays 1. The next ack clears it and irq falls one cycle later.
